// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, IF/ID FSM state encodings and
// register-field bit positions used by the front-end pipeline.
package cpu_pkg;

  localparam int          DATA_W    = 32;
  localparam int          REG_W     = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } if_state_t;

  function automatic logic [REG_W-1:0] rs_of(input logic [DATA_W-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [REG_W-1:0] rt_of(input logic [DATA_W-1:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// IF/ID stage signal bundle. Optional perf counters appear only when
// IFID_PERF_CNT_EN is defined.
interface if_id_stage_if;

  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        pc_new_en;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        bubble;
  logic        ex_nop;
  logic [1:0]  if_state;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport slave (
    input  pc_in, instr_in, pc_new_en, ex_memread, ex_rt,
    output id_pc, id_pc4, id_instr, id_valid, bubble, ex_nop, if_state
`ifdef IFID_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport master (
    output pc_in, instr_in, pc_new_en, ex_memread, ex_rt,
    input  id_pc, id_pc4, id_instr, id_valid, bubble, ex_nop, if_state
`ifdef IFID_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX writing a register that the
// instruction in ID reads as rs or rt. Register 0 never creates a hazard.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_instr,
  input  logic              ex_memread,
  input  logic [REG_W-1:0]  ex_rt,
  output logic              hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == rs_of(id_instr));
  assign rt_hit = (ex_rt == rt_of(id_instr));
  assign hazard = id_valid & ex_memread & (ex_rt != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush/stall FSM and load-use bubble request.
// Define IFID_PERF_CNT_EN to add the stall_cnt/flush_cnt counters.
module if_id_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  if_id_stage_if.slave   bus
);

  if_state_t         state_q;
  if_state_t         state_d;
  logic              hazard;
  logic [DATA_W-1:0] id_pc_p1;
  logic [DATA_W-1:0] id_pc4_p1;
  logic [DATA_W-1:0] id_instr_p1;
  logic              vld_p1;

  hazard_detect u_hazard_detect (
    .id_valid   (vld_p1),
    .id_instr   (id_instr_p1),
    .ex_memread (bus.ex_memread),
    .ex_rt      (bus.ex_rt),
    .hazard     (hazard)
  );

  // Next action depends only on this cycle's inputs, so an illegal state
  // code never influences the next one.
  always_comb begin
    state_d = ST_RUN;
    if (bus.pc_new_en) begin
      state_d = ST_FLUSH;
    end else if (hazard) begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // IF -> ID register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_p1    <= '0;
      id_pc4_p1   <= '0;
      id_instr_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      case (state_d)
        ST_RUN: begin
          id_pc_p1    <= bus.pc_in;
          id_pc4_p1   <= bus.pc_in + 32'h4;
          id_instr_p1 <= bus.instr_in;
          vld_p1      <= 1'b1;
        end
        ST_FLUSH: begin
          id_instr_p1 <= NOP_INSTR;
          vld_p1      <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.id_pc    = id_pc_p1;
  assign bus.id_pc4   = id_pc4_p1;
  assign bus.id_instr = id_instr_p1;
  assign bus.id_valid = vld_p1;
  assign bus.bubble   = hazard & ~bus.pc_new_en;
  assign bus.ex_nop   = hazard & ~bus.pc_new_en;
  assign bus.if_state = state_q;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_d == ST_STALL) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_d == ST_FLUSH) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, reset corner sequences and
// randomized traffic against a behavioural model.
module tb_if_id_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pn;
    logic        mr;
    logic [4:0]  rt;
    logic        eb;
    logic [31:0] epc;
    logic [31:0] epc4;
    logic [31:0] ei;
    logic        ev;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[12];

  // behavioural model state
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  logic [1:0]  m_state;
  logic [31:0] m_stall, m_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] i,
                       input logic pn, input logic mr, input logic [4:0] rt);
    rst            = r;
    bus.pc_in      = p;
    bus.instr_in   = i;
    bus.pc_new_en  = pn;
    bus.ex_memread = mr;
    bus.ex_rt      = rt;
  endtask

  function automatic logic model_hazard(input logic mr, input logic [4:0] rt);
    logic [4:0] rs_f, rt_f;
    rs_f = 5'((m_instr >> 21) & 32'h1F);
    rt_f = 5'((m_instr >> 16) & 32'h1F);
    return m_valid && mr && rt != 0 && (rt == rs_f || rt == rt_f);
  endfunction

  task automatic model_edge(input logic r, input logic [31:0] p, input logic [31:0] i,
                            input logic pn, input logic hz);
    if (r) begin
      m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_state = 0;
      m_stall = 0; m_flush = 0;
    end else if (pn) begin
      m_instr = 0; m_valid = 0; m_state = 2; m_flush = m_flush + 1;
    end else if (hz) begin
      m_state = 1; m_stall = m_stall + 1;
    end else begin
      m_pc = p; m_pc4 = 32'((64'(p) + 64'd4) % 64'h1_0000_0000);
      m_instr = i; m_valid = 1; m_state = 0;
    end
  endtask

  task automatic reset_dut();
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    model_edge(1'b1, 0, 0, 0, 0);
  endtask

  initial begin
    logic hz, eb;
    logic r, pn, mr;
    logic [4:0]  rt;
    logic [31:0] p, i;

    tbl[0]  = '{32'h10,       32'h8C22_0004, 0, 0, 5'd0,  0, 32'h10,       32'h14,       32'h8C22_0004, 1, 2'd0};
    tbl[1]  = '{32'h14,       32'h0043_0820, 0, 0, 5'd0,  0, 32'h14,       32'h18,       32'h0043_0820, 1, 2'd0};
    tbl[2]  = '{32'h18,       32'h1111_1111, 0, 1, 5'd2,  1, 32'h14,       32'h18,       32'h0043_0820, 1, 2'd1};
    tbl[3]  = '{32'h18,       32'h1111_1111, 0, 0, 5'd0,  0, 32'h18,       32'h1C,       32'h1111_1111, 1, 2'd0};
    tbl[4]  = '{32'h1C,       32'h2222_2222, 1, 1, 5'd17, 0, 32'h18,       32'h1C,       32'h0000_0000, 0, 2'd2};
    tbl[5]  = '{32'h40,       32'h0000_0000, 0, 1, 5'd0,  0, 32'h40,       32'h44,       32'h0000_0000, 1, 2'd0};
    tbl[6]  = '{32'hFFFF_FFFC, 32'hAAAA_5555, 0, 1, 5'd0,  0, 32'hFFFF_FFFC, 32'h0,        32'hAAAA_5555, 1, 2'd0};
    tbl[7]  = '{32'h50,       32'h3333_3333, 0, 1, 5'd10, 1, 32'hFFFF_FFFC, 32'h0,        32'hAAAA_5555, 1, 2'd1};
    tbl[8]  = '{32'h50,       32'h3333_3333, 0, 1, 5'd21, 1, 32'hFFFF_FFFC, 32'h0,        32'hAAAA_5555, 1, 2'd1};
    tbl[9]  = '{32'h50,       32'h3333_3333, 1, 0, 5'd0,  0, 32'hFFFF_FFFC, 32'h0,        32'h0000_0000, 0, 2'd2};
    tbl[10] = '{32'h60,       32'h4444_4444, 1, 1, 5'd3,  0, 32'hFFFF_FFFC, 32'h0,        32'h0000_0000, 0, 2'd2};
    tbl[11] = '{32'h100,      32'h1234_5678, 0, 0, 5'd0,  0, 32'h100,      32'h104,      32'h1234_5678, 1, 2'd0};

    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    reset_dut();
    chk("rst_id_pc",    bus.id_pc,    32'h0);
    chk("rst_id_pc4",   bus.id_pc4,   32'h0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_if_state", 32'(bus.if_state), 32'h0);
    chk("rst_bubble",   32'(bus.bubble),   32'h0);
`ifdef IFID_PERF_CNT_EN
    chk("rst_stall_cnt", bus.stall_cnt, 32'h0);
    chk("rst_flush_cnt", bus.flush_cnt, 32'h0);
`endif

    // directed vectors
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, tbl[k].pc, tbl[k].instr, tbl[k].pn, tbl[k].mr, tbl[k].rt);
      #1;
      chk($sformatf("v%0d_bubble", k), 32'(bus.bubble), 32'(tbl[k].eb));
      chk($sformatf("v%0d_ex_nop", k), 32'(bus.ex_nop), 32'(tbl[k].eb));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_id_pc", k),    bus.id_pc,    tbl[k].epc);
      chk($sformatf("v%0d_id_pc4", k),   bus.id_pc4,   tbl[k].epc4);
      chk($sformatf("v%0d_id_instr", k), bus.id_instr, tbl[k].ei);
      chk($sformatf("v%0d_id_valid", k), 32'(bus.id_valid), 32'(tbl[k].ev));
      chk($sformatf("v%0d_if_state", k), 32'(bus.if_state), 32'(tbl[k].es));
    end
`ifdef IFID_PERF_CNT_EN
    chk("tbl_stall_cnt", bus.stall_cnt, 32'd3);
    chk("tbl_flush_cnt", bus.flush_cnt, 32'd3);
`endif

    // reset while a stall is requested
    drive(1'b0, 32'h20, 32'h0043_0820, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h24, 32'h5555_5555, 1'b0, 1'b1, 5'd2);
    #1;
    chk("rst_stall_bubble_before", 32'(bus.bubble), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall_state", 32'(bus.if_state), 32'h0);
    chk("rst_stall_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_stall_pc",    bus.id_pc,         32'h0);
`ifdef IFID_PERF_CNT_EN
    chk("rst_stall_cnt",   bus.stall_cnt,     32'h0);
`endif
    drive(1'b0, 32'h24, 32'h5555_5555, 1'b0, 1'b1, 5'd2);
    #1;
    chk("rst_stall_bubble_after", 32'(bus.bubble), 32'h0);
    @(posedge clk);
    @(negedge clk);
    // reset while a flush is requested
    drive(1'b1, 32'h30, 32'h6666_6666, 1'b1, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_flush_state", 32'(bus.if_state), 32'h0);
    chk("rst_flush_instr", bus.id_instr,      32'h0);
`ifdef IFID_PERF_CNT_EN
    chk("rst_flush_cnt",   bus.flush_cnt,     32'h0);
`endif

    // randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 39) == 0);
      pn = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 1) == 1);
      rt = 5'($urandom_range(0, 3));
      p  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      i  = $urandom;
      i[25:21] = 5'($urandom_range(0, 3));
      i[20:16] = 5'($urandom_range(0, 3));
      drive(r, p, i, pn, mr, rt);
      #1;
      hz = model_hazard(mr, rt);
      eb = hz && !pn;
      chk("rnd_bubble", 32'(bus.bubble), 32'(eb));
      chk("rnd_ex_nop", 32'(bus.ex_nop), 32'(eb));
      @(posedge clk);
      model_edge(r, p, i, pn, hz);
      @(negedge clk);
      chk("rnd_id_pc",    bus.id_pc,    m_pc);
      chk("rnd_id_pc4",   bus.id_pc4,   m_pc4);
      chk("rnd_id_instr", bus.id_instr, m_instr);
      chk("rnd_id_valid", 32'(bus.id_valid), 32'(m_valid));
      chk("rnd_if_state", 32'(bus.if_state), 32'(m_state));
`ifdef IFID_PERF_CNT_EN
      chk("rnd_stall_cnt", bus.stall_cnt, m_stall);
      chk("rnd_flush_cnt", bus.flush_cnt, m_flush);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
